// File: rtl/tag_freelist_pkg.sv
// rtl/tag_freelist_pkg.sv - shared widths and types for the tag free list
package tag_freelist_pkg;

  localparam int TAG_W    = 5;
  localparam int NUM_TAGS = 1 << TAG_W;
  // index plus wrap bit; derived, never overridden
  localparam int PTR_W    = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [TAG_W:0]   cnt_t;

  localparam cnt_t NUM_TAGS_CNT = cnt_t'(NUM_TAGS);
  localparam ptr_t NUM_TAGS_PTR = ptr_t'(NUM_TAGS);

endpackage

// File: rtl/tag_freelist_ram.sv
// rtl/tag_freelist_ram.sv - NUM_TAGS x TAG_W register array, 2 async reads, 2 sync writes
module tag_freelist_ram
  import tag_freelist_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [TAG_W-1:0] rd_addr0,
  input  logic [TAG_W-1:0] rd_addr1,
  output logic [TAG_W-1:0] rd_data0,
  output logic [TAG_W-1:0] rd_data1,
  input  logic             wr_en0,
  input  logic [TAG_W-1:0] wr_addr0,
  input  logic [TAG_W-1:0] wr_data0,
  input  logic             wr_en1,
  input  logic [TAG_W-1:0] wr_addr1,
  input  logic [TAG_W-1:0] wr_data1
);

  tag_t mem_q [NUM_TAGS];
  tag_t mem_d [NUM_TAGS];

  // Reads are combinational so a write this cycle is only visible next cycle.
  assign rd_data0 = mem_q[rd_addr0];
  assign rd_data1 = mem_q[rd_addr1];

  // Next array contents: the two write ports never target the same slot.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en0) begin
      mem_d[wr_addr0] = wr_data0;
    end
    if (wr_en1) begin
      mem_d[wr_addr1] = wr_data1;
    end
  end

  // Array register; reset loads the identity permutation mem[i] = i.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        mem_q[i] <= tag_t'(i);
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/tag_freelist.sv
// rtl/tag_freelist.sv - dual-issue/dual-retire tag free list; optional TAG_FREELIST_DUP_CHECK_EN
module tag_freelist
  import tag_freelist_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             Rd_en0,
  input  logic             Rd_en1,
  output logic [TAG_W-1:0] Tag_Out0,
  output logic [TAG_W-1:0] Tag_Out1,
  output logic             Tag_Valid0,
  output logic             Tag_Valid1,
  input  logic [TAG_W-1:0] RB_Tag0,
  input  logic [TAG_W-1:0] RB_Tag1,
  input  logic             RB_Tag_Valid0,
  input  logic             RB_Tag_Valid1,
  input  logic             Flush,
  output logic [TAG_W:0]   Free_Count,
  output logic             tagFifo_full,
  output logic             tagFifo_empty,
  output logic             Err_Overflow,
  output logic             Err_Dup
);

  ptr_t rptr_q, rptr_d;
  ptr_t wptr_q, wptr_d;
  logic err_ovf_q, err_ovf_d;

  cnt_t free_count;
  cnt_t nrd;
  cnt_t space;
  logic rd0, rd1;
  logic dup0, dup1;
  logic want0, want1;
  logic acc0, acc1;
  logic we0, we1;
  tag_t wa0, wa1;
  tag_t ra0, ra1;

  assign free_count    = wptr_q - rptr_q;
  assign Free_Count    = free_count;
  assign Tag_Valid0    = (free_count != '0);
  assign Tag_Valid1    = (free_count >= cnt_t'(2));
  assign tagFifo_full  = (wptr_q[TAG_W] != rptr_q[TAG_W]) &&
                         (wptr_q[TAG_W-1:0] == rptr_q[TAG_W-1:0]);
  assign tagFifo_empty = (wptr_q == rptr_q);
  assign Err_Overflow  = err_ovf_q;

  // Lookahead reads: the head two slots are always on the outputs.
  assign ra0 = rptr_q[TAG_W-1:0];
  assign ra1 = ra0 + tag_t'(1);

  tag_freelist_ram u_ram (
    .clock    (clock),
    .reset    (reset),
    .rd_addr0 (ra0),
    .rd_addr1 (ra1),
    .rd_data0 (Tag_Out0),
    .rd_data1 (Tag_Out1),
    .wr_en0   (we0),
    .wr_addr0 (wa0),
    .wr_data0 (RB_Tag0),
    .wr_en1   (we1),
    .wr_addr1 (wa1),
    .wr_data1 (RB_Tag1)
  );

  // Grant arithmetic: reads granted first, returns limited to the room left after them.
  always_comb begin
    rd0   = Rd_en0 & Tag_Valid0;
    rd1   = rd0 & Rd_en1 & Tag_Valid1;
    nrd   = cnt_t'(rd0) + cnt_t'(rd1);
    space = NUM_TAGS_CNT - (free_count - nrd);
    want0 = RB_Tag_Valid0 & ~dup0;
    want1 = RB_Tag_Valid1 & ~dup1;
    acc0  = want0 & (space != '0);
    acc1  = want1 & (space >= (acc0 ? cnt_t'(2) : cnt_t'(1)));
  end

`ifdef TAG_FREELIST_DUP_CHECK_EN
  logic [NUM_TAGS-1:0] free_vec_q, free_vec_d;
  logic                err_dup_q, err_dup_d;

  // A return of a tag already marked free is a duplicate; same tag twice drops port 1.
  assign dup0    = RB_Tag_Valid0 & free_vec_q[RB_Tag0];
  assign dup1    = RB_Tag_Valid1 &
                   (free_vec_q[RB_Tag1] | (RB_Tag_Valid0 & (RB_Tag0 == RB_Tag1)));
  assign Err_Dup = err_dup_q;

  // Free vector tracking: reads clear, accepted returns set, flush sets all.
  always_comb begin
    free_vec_d = free_vec_q;
    err_dup_d  = err_dup_q;
    if (Flush) begin
      free_vec_d = '1;
    end else begin
      if (rd0) free_vec_d[Tag_Out0] = 1'b0;
      if (rd1) free_vec_d[Tag_Out1] = 1'b0;
      if (acc0) free_vec_d[RB_Tag0] = 1'b1;
      if (acc1) free_vec_d[RB_Tag1] = 1'b1;
      if (dup0 | dup1) err_dup_d = 1'b1;
    end
  end

  // Free vector and sticky duplicate flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_vec_q <= '1;
      err_dup_q  <= 1'b0;
    end else begin
      free_vec_q <= free_vec_d;
      err_dup_q  <= err_dup_d;
    end
  end
`else
  assign dup0    = 1'b0;
  assign dup1    = 1'b0;
  assign Err_Dup = 1'b0;
`endif

  // Pointer/write-port next state; flush rewinds rptr to reclaim every in-flight tag.
  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    err_ovf_d = err_ovf_q;
    we0       = 1'b0;
    we1       = 1'b0;
    wa0       = wptr_q[TAG_W-1:0];
    wa1       = wptr_q[TAG_W-1:0] + tag_t'(acc0);
    if (Flush) begin
      rptr_d = wptr_q - NUM_TAGS_PTR;
    end else begin
      rptr_d = rptr_q + ptr_t'(nrd);
      wptr_d = wptr_q + ptr_t'(acc0) + ptr_t'(acc1);
      we0    = acc0;
      we1    = acc1;
      if ((want0 & ~acc0) | (want1 & ~acc1)) begin
        err_ovf_d = 1'b1;
      end
    end
  end

  // Pointer and sticky overflow registers; reset starts with every tag free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr_q    <= '0;
      wptr_q    <= NUM_TAGS_PTR;
      err_ovf_q <= 1'b0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_tag_freelist.sv
// tb/tb_tag_freelist.sv - self-checking bench for tag_freelist with a log-based model
module tb_tag_freelist;

  localparam int NT = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Rd_en0 = 1'b0, Rd_en1 = 1'b0;
  logic [4:0] Tag_Out0, Tag_Out1;
  logic       Tag_Valid0, Tag_Valid1;
  logic [4:0] RB_Tag0 = '0, RB_Tag1 = '0;
  logic       RB_Tag_Valid0 = 1'b0, RB_Tag_Valid1 = 1'b0;
  logic       Flush = 1'b0;
  logic [5:0] Free_Count;
  logic       tagFifo_full, tagFifo_empty, Err_Overflow, Err_Dup;

  always #5 clock = ~clock;

  tag_freelist dut (
    .clock(clock), .reset(reset), .Rd_en0(Rd_en0), .Rd_en1(Rd_en1),
    .Tag_Out0(Tag_Out0), .Tag_Out1(Tag_Out1),
    .Tag_Valid0(Tag_Valid0), .Tag_Valid1(Tag_Valid1),
    .RB_Tag0(RB_Tag0), .RB_Tag1(RB_Tag1),
    .RB_Tag_Valid0(RB_Tag_Valid0), .RB_Tag_Valid1(RB_Tag_Valid1),
    .Flush(Flush), .Free_Count(Free_Count),
    .tagFifo_full(tagFifo_full), .tagFifo_empty(tagFifo_empty),
    .Err_Overflow(Err_Overflow), .Err_Dup(Err_Dup)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a log of every tag ever placed in the free list, plus a head index.
  // The free tags are log[head .. end]; a flush makes the last NT log entries free.
  int hist[$];
  int head;
  bit m_ovf, m_dup;
  bit inflight[NT];

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < NT; i++) hist.push_back(i);
    head  = 0;
    m_ovf = 0;
    m_dup = 0;
    for (int i = 0; i < NT; i++) inflight[i] = 0;
  endtask

  task automatic m_step();
    int fc, nrd, room;
    bit r0, r1, d0, d1, w0, w1, a0, a1;
    fc = hist.size() - head;
    if (Flush) begin
      head = hist.size() - NT;
      for (int i = 0; i < NT; i++) inflight[i] = 0;
      return;
    end
    r0 = Rd_en0 && fc >= 1;
    r1 = r0 && Rd_en1 && fc >= 2;
    nrd = int'(r0) + int'(r1);
    d0 = 0;
    d1 = 0;
`ifdef TAG_FREELIST_DUP_CHECK_EN
    d0 = RB_Tag_Valid0 && !inflight[RB_Tag0];
    d1 = RB_Tag_Valid1 && (!inflight[RB_Tag1] || (RB_Tag_Valid0 && RB_Tag0 == RB_Tag1));
    if (d0 || d1) m_dup = 1;
`endif
    room = NT - (fc - nrd);
    w0 = RB_Tag_Valid0 && !d0;
    w1 = RB_Tag_Valid1 && !d1;
    a0 = w0 && room >= 1;
    if (a0) room--;
    a1 = w1 && room >= 1;
    if ((w0 && !a0) || (w1 && !a1)) m_ovf = 1;
    if (r0) inflight[hist[head]] = 1;
    if (r1) inflight[hist[head+1]] = 1;
    head += nrd;
    if (a0) begin hist.push_back(int'(RB_Tag0)); inflight[RB_Tag0] = 0; end
    if (a1) begin hist.push_back(int'(RB_Tag1)); inflight[RB_Tag1] = 0; end
  endtask

  initial m_reset();

  always @(posedge clock) begin
    if (reset) m_reset();
    else m_step();
  end

  // Compare process: every falling edge, outputs against the model.
  int cfc;
  always @(negedge clock) begin
    cfc = hist.size() - head;
    chk("free_count", int'(Free_Count), cfc);
    chk("tag_valid0", int'(Tag_Valid0), int'(cfc >= 1));
    chk("tag_valid1", int'(Tag_Valid1), int'(cfc >= 2));
    chk("full", int'(tagFifo_full), int'(cfc == NT));
    chk("empty", int'(tagFifo_empty), int'(cfc == 0));
    if (cfc >= 1) chk("tag_out0", int'(Tag_Out0), hist[head]);
    if (cfc >= 2) chk("tag_out1", int'(Tag_Out1), hist[head+1]);
    chk("err_overflow", int'(Err_Overflow), int'(m_ovf));
    chk("err_dup", int'(Err_Dup), int'(m_dup));
  end

  task automatic idle();
    Rd_en0 = 0; Rd_en1 = 0; RB_Tag_Valid0 = 0; RB_Tag_Valid1 = 0; Flush = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  function automatic int pick();
    int s;
    s = $urandom_range(NT-1);
    for (int k = 0; k < NT; k++) if (inflight[(s+k)%NT]) return (s+k)%NT;
    return s;
  endfunction

`ifdef TAG_FREELIST_DUP_CHECK_EN
  localparam int RA = 3, RB = 1;
`else
  localparam int RA = 7, RB = 2;
`endif

  initial begin
    int seen_cnt;
    bit seen[NT];

    // 1: single reads drain 0..31 in order
    @(negedge clock); #1;
    do_reset();
    chk("t1_reset_fc", int'(Free_Count), 32);
    chk("t1_reset_tag0", int'(Tag_Out0), 0);
    chk("t1_reset_tag1", int'(Tag_Out1), 1);
    chk("t1_reset_full", int'(tagFifo_full), 1);
    chk("t1_reset_empty", int'(tagFifo_empty), 0);
    for (int i = 0; i < NT; i++) begin
      chk("t1_tag_seq", int'(Tag_Out0), i);
      Rd_en0 = 1;
      tick();
    end
    idle();
    chk("t1_empty", int'(tagFifo_empty), 1);
    chk("t1_valid0", int'(Tag_Valid0), 0);
    chk("t1_fc", int'(Free_Count), 0);
    Rd_en0 = 1; Rd_en1 = 1;
    tick();
    idle();
    chk("t1_read_empty_err", int'(Err_Overflow), 0);

    // 2: Rd_en1 alone ignored; dual reads give pairs
    do_reset();
    Rd_en1 = 1;
    tick();
    chk("t2_rd1_alone_fc", int'(Free_Count), 32);
    chk("t2_rd1_alone_tag0", int'(Tag_Out0), 0);
    for (int i = 0; i < NT/2; i++) begin
      chk("t2_pair0", int'(Tag_Out0), 2*i);
      chk("t2_pair1", int'(Tag_Out1), 2*i+1);
      Rd_en0 = 1; Rd_en1 = 1;
      tick();
    end
    idle();
    chk("t2_empty", int'(tagFifo_empty), 1);

    // 3: take 4, return two in one cycle, then drain
    do_reset();
    Rd_en0 = 1; Rd_en1 = 1;
    tick(); tick();
    idle();
    chk("t3_fc28", int'(Free_Count), 28);
    RB_Tag_Valid0 = 1; RB_Tag0 = 5'(RA);
    RB_Tag_Valid1 = 1; RB_Tag1 = 5'(RB);
    tick();
    idle();
    chk("t3_fc30", int'(Free_Count), 30);
    for (int i = 4; i < NT; i++) begin
      chk("t3_seq", int'(Tag_Out0), i);
      Rd_en0 = 1;
      tick();
    end
    chk("t3_ret0", int'(Tag_Out0), RA);
    chk("t3_ret1", int'(Tag_Out1), RB);
    idle();

    // 4: return into a full list
    do_reset();
    RB_Tag_Valid0 = 1; RB_Tag0 = 5'd5;
    tick();
    idle();
`ifdef TAG_FREELIST_DUP_CHECK_EN
    chk("t4_dup_full", int'(Err_Dup), 1);
    chk("t4_no_ovf", int'(Err_Overflow), 0);
`else
    chk("t4_ovf", int'(Err_Overflow), 1);
    chk("t4_fc", int'(Free_Count), 32);
    Rd_en0 = 1; RB_Tag_Valid0 = 1; RB_Tag0 = 5'd9;
    tick();
    idle();
    chk("t4_rw_fc", int'(Free_Count), 32);
    chk("t4_rw_tag0", int'(Tag_Out0), 1);
    chk("t4_ovf_sticky", int'(Err_Overflow), 1);
`endif
    Rd_en0 = 1;
    tick(); tick(); tick();
    idle();
    // asynchronous reset mid-operation
    reset = 1;
    #1;
    chk("t4_async_fc", int'(Free_Count), 32);
    chk("t4_async_tag0", int'(Tag_Out0), 0);
    chk("t4_async_tag1", int'(Tag_Out1), 1);
    chk("t4_async_ovf", int'(Err_Overflow), 0);
    tick();
    reset = 0;

    // 5: flush wins over same-cycle read and return
    do_reset();
    for (int i = 0; i < 5; i++) begin
      Rd_en0 = 1; Rd_en1 = 1;
      tick();
    end
    idle();
    chk("t5_fc22", int'(Free_Count), 22);
    Flush = 1; Rd_en0 = 1; RB_Tag_Valid0 = 1; RB_Tag0 = 5'd3;
    tick();
    idle();
    chk("t5_fc32", int'(Free_Count), 32);
    chk("t5_tag0", int'(Tag_Out0), 0);
    chk("t5_no_ovf", int'(Err_Overflow), 0);
    for (int i = 0; i < NT; i++) seen[i] = 0;
    for (int i = 0; i < NT; i++) begin
      seen[Tag_Out0] = 1;
      Rd_en0 = 1;
      tick();
    end
    idle();
    seen_cnt = 0;
    for (int i = 0; i < NT; i++) seen_cnt += int'(seen[i]);
    chk("t5_perm", seen_cnt, 32);

    // 6: returning a tag that is already free
    do_reset();
    Rd_en0 = 1;
    tick(); tick();
    idle();
    RB_Tag_Valid0 = 1; RB_Tag0 = 5'd5;
    tick();
    idle();
`ifdef TAG_FREELIST_DUP_CHECK_EN
    chk("t6_dup", int'(Err_Dup), 1);
    chk("t6_fc", int'(Free_Count), 30);
    RB_Tag_Valid0 = 1; RB_Tag0 = 5'd1; RB_Tag_Valid1 = 1; RB_Tag1 = 5'd1;
    tick();
    idle();
    chk("t6_same_tag_fc", int'(Free_Count), 31);
`else
    chk("t6_nodup", int'(Err_Dup), 0);
    chk("t6_fc", int'(Free_Count), 31);
`endif

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(499) == 0) begin
        reset = 1;
        tick();
        reset = 0;
        continue;
      end
      Rd_en0 = $urandom_range(1);
      Rd_en1 = $urandom_range(1);
      RB_Tag_Valid0 = ($urandom_range(2) != 0);
      RB_Tag_Valid1 = ($urandom_range(2) != 0);
      RB_Tag0 = ($urandom_range(15) == 0) ? 5'($urandom_range(NT-1)) : 5'(pick());
      RB_Tag1 = ($urandom_range(15) == 0) ? 5'($urandom_range(NT-1)) : 5'(pick());
      Flush = ($urandom_range(63) == 0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
